// File: rtl/scan_seq_3to8.sv
// scan_seq_3to8: registered scan sequencer that drives the select and enable
// pins of a 3-to-8 active-low decoder.
// It visits the masked-in channels in ascending order. Each channel gets a
// blanking gap with the enables off, followed by a dwell with the enables on.
// Control: start_i is a level that is sampled only in IDLE. stop_i is a level
// that aborts the scan from any busy state and wins over start_i and over the
// end of a pass.
module scan_seq_3to8 #(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               oneshot_i,
  input  logic [7:0]         mask_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2:0]         chan_o,
  output logic               select_a_o,
  output logic               select_b_o,
  output logic               select_c_o,
  output logic               g1_en_o,
  output logic               g2a_en_n_o,
  output logic               g2b_en_n_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  localparam int BCW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BCW-1:0] BLANK_LAST = BCW'(BLANK_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_chan, w_chan_nxt;
  logic [BCW-1:0]       r_bcnt, w_bcnt_nxt;
  logic [DWELL_W-1:0]   r_dcnt, w_dcnt_nxt;
  logic [7:0]           r_mask, w_mask_nxt;
  logic [DWELL_W-1:0]   r_dwell, w_dwell_nxt;
  logic                 r_oneshot, w_oneshot_nxt;
  logic                 r_busy, r_done, r_en;
  logic                 w_done_nxt;
  logic [7:0]           w_le_mask;
  logic [7:0]           w_above;
  logic                 w_has_next;

  // Index of the lowest set bit. The result is only meaningful when m != 0.
  function automatic logic [2:0] f_lowest(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Latched-mask bits strictly above the current channel.
  // For chan=7 the shift wraps to zero in 8 bits, so the mask becomes all
  // ones and nothing is left above.
  assign w_le_mask  = (8'd2 << r_chan) - 8'd1;
  assign w_above    = r_mask & ~w_le_mask;
  assign w_has_next = |w_above;

  // Next-state, counter and channel selection.
  always_comb begin
    w_state_nxt   = r_state;
    w_chan_nxt    = r_chan;
    w_bcnt_nxt    = r_bcnt;
    w_dcnt_nxt    = r_dcnt;
    w_mask_nxt    = r_mask;
    w_dwell_nxt   = r_dwell;
    w_oneshot_nxt = r_oneshot;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i && !stop_i && (mask_i != 8'd0)) begin
          w_mask_nxt    = mask_i;
          w_dwell_nxt   = dwell_i;
          w_oneshot_nxt = oneshot_i;
          w_chan_nxt    = f_lowest(mask_i);
          w_bcnt_nxt    = '0;
          w_state_nxt   = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (stop_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_bcnt == BLANK_LAST) begin
          w_dcnt_nxt  = '0;
          w_state_nxt = ST_DRIVE;
        end else begin
          w_bcnt_nxt = r_bcnt + BCW'(1);
        end
      end
      ST_DRIVE: begin
        if (stop_i) begin
          w_state_nxt = ST_IDLE;
        end else if (r_dcnt == r_dwell) begin
          w_bcnt_nxt = '0;
          if (w_has_next) begin
            w_chan_nxt  = f_lowest(w_above);
            w_state_nxt = ST_BLANK;
          end else if (r_oneshot) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_chan_nxt  = f_lowest(r_mask);
            w_state_nxt = ST_BLANK;
          end
        end else begin
          w_dcnt_nxt = r_dcnt + DWELL_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters, latched scan setup and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_chan    <= 3'd0;
      r_bcnt    <= '0;
      r_dcnt    <= '0;
      r_mask    <= 8'd0;
      r_dwell   <= '0;
      r_oneshot <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_en      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_chan    <= w_chan_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_mask    <= w_mask_nxt;
      r_dwell   <= w_dwell_nxt;
      r_oneshot <= w_oneshot_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
      r_en      <= (w_state_nxt == ST_DRIVE);
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign chan_o     = r_chan;
  assign select_a_o = r_chan[0];
  assign select_b_o = r_chan[1];
  assign select_c_o = r_chan[2];
  assign g1_en_o    = r_en;
  assign g2a_en_n_o = ~r_en;
  assign g2b_en_n_o = ~r_en;
  assign state_o    = r_state;

endmodule

// File: tb/tb_scan_seq_3to8.sv
// Directed testbench for scan_seq_3to8 (DWELL_W=8, BLANK_CYCLES=2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_scan_seq_3to8;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       start_i, stop_i, oneshot_i;
  logic [7:0] mask_i;
  logic [7:0] dwell_i;
  logic       busy_o, done_o;
  logic [2:0] chan_o;
  logic       select_a_o, select_b_o, select_c_o;
  logic       g1_en_o, g2a_en_n_o, g2b_en_n_o;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] exp_q[$];

  scan_seq_3to8 #(.DWELL_W(8), .BLANK_CYCLES(2)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .oneshot_i  (oneshot_i),
    .mask_i     (mask_i),
    .dwell_i    (dwell_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .chan_o     (chan_o),
    .select_a_o (select_a_o),
    .select_b_o (select_b_o),
    .select_c_o (select_c_o),
    .g1_en_o    (g1_en_o),
    .g2a_en_n_o (g2a_en_n_o),
    .g2b_en_n_o (g2b_en_n_o),
    .state_o    (state_o)
  );

  // Clock generation.
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Observed output vector: {busy,done,g1,g2a_n,g2b_n,sel_c,sel_b,sel_a,chan}.
  function automatic logic [31:0] obs_vec();
    return {21'd0, busy_o, done_o, g1_en_o, g2a_en_n_o, g2b_en_n_o,
            select_c_o, select_b_o, select_a_o, chan_o};
  endfunction

  function automatic logic [31:0] mk(input logic busy, input logic done,
                                     input logic en, input logic [2:0] ch);
    return {21'd0, busy, done, en, ~en, ~en, ch, ch};
  endfunction

  task automatic do_start(input logic [7:0] m, input logic [7:0] d, input logic os);
    mask_i    = m;
    dwell_i   = d;
    oneshot_i = os;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  initial begin
    logic       prev_en;
    int         run;
    int         en_cnt;
    int         done_cnt;
    int         bad_sel;
    int         k;
    logic [2:0] ch_exp;
    logic [2:0] popped;

    rst_n_i   = 1'b0;
    start_i   = 1'b0;
    stop_i    = 1'b0;
    oneshot_i = 1'b0;
    mask_i    = 8'd0;
    dwell_i   = 8'd0;
    #22;
    check("reset_outputs", obs_vec(), mk(0, 0, 0, 3'd0));
    check("reset_state", {30'd0, state_o}, 32'd0);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    tick();

    // Full one-shot pass: 8 channels x (2 blank + 1 drive) = 24 cycles.
    do_start(8'hFF, 8'd0, 1'b1);
    check("full_first_state", {30'd0, state_o}, 32'd1);
    for (int t = 0; t < 24; t++) begin
      check($sformatf("full_t%0d", t), obs_vec(), mk(1, 0, (t % 3) == 2, 3'(t / 3)));
      tick();
    end
    check("full_done_edge", obs_vec(), mk(0, 1, 0, 3'd7));
    tick();
    check("full_done_clear", obs_vec(), mk(0, 0, 0, 3'd7));

    // Sparse continuous mask 0x81, dwell 3: 0,7,0,7,... with 4 drive cycles each.
    exp_q = {3'd0, 3'd7, 3'd0, 3'd7, 3'd0};
    do_start(8'h81, 8'd3, 1'b0);
    prev_en = 1'b0;
    run = 0;
    for (int t = 0; t < 30; t++) begin
      ch_exp = ((t / 6) % 2) ? 3'd7 : 3'd0;
      check($sformatf("sparse_t%0d", t), obs_vec(), mk(1, 0, (t % 6) >= 2, ch_exp));
      if (g1_en_o && !prev_en) begin
        if (exp_q.size() > 0) begin
          popped = exp_q.pop_front();
          check("sparse_sb_chan", {29'd0, chan_o}, {29'd0, popped});
        end else begin
          check("sparse_sb_extra", 32'd1, 32'd0);
        end
        run = 1;
      end else if (g1_en_o) begin
        run++;
      end else if (prev_en) begin
        check("sparse_sb_run", run, 32'd4);
      end
      prev_en = g1_en_o;
      // Changes while busy must be ignored.
      if (t == 3) begin
        mask_i  = 8'h02;
        dwell_i = 8'd0;
        start_i = 1'b1;
      end else if (t == 4) begin
        start_i = 1'b0;
      end
      tick();
    end
    check("sparse_sb_empty", exp_q.size(), 32'd0);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("sparse_stop", obs_vec(), mk(0, 0, 0, 3'd7));

    // A zero mask is ignored.
    do_start(8'h00, 8'd0, 1'b1);
    check("zero_mask_a", obs_vec(), mk(0, 0, 0, 3'd7));
    tick();
    check("zero_mask_b", obs_vec(), mk(0, 0, 0, 3'd7));

    // stop_i blocks start_i in IDLE.
    stop_i = 1'b1;
    do_start(8'hFF, 8'd0, 1'b1);
    stop_i = 1'b0;
    check("start_with_stop", obs_vec(), mk(0, 0, 0, 3'd7));

    // Stop during DRIVE of channel 3 (dwell 5 gives a period of 8, ch3 drives at t=26..31).
    do_start(8'hFF, 8'd5, 1'b1);
    for (int t = 0; t < 28; t++) tick();
    check("stop3_in_drive", obs_vec(), mk(1, 0, 1, 3'd3));
    check("stop3_state", {30'd0, state_o}, 32'd2);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("stop3_next_edge", obs_vec(), mk(0, 0, 0, 3'd3));
    tick();
    check("stop3_hold", obs_vec(), mk(0, 0, 0, 3'd3));
    do_start(8'hFF, 8'd5, 1'b1);
    check("restart_lowest", obs_vec(), mk(1, 0, 0, 3'd0));
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("restart_stop", obs_vec(), mk(0, 0, 0, 3'd0));

    // Stop on the final DRIVE cycle of a one-shot pass gives no done_o.
    do_start(8'h80, 8'd0, 1'b1);
    check("final_blank", obs_vec(), mk(1, 0, 0, 3'd7));
    tick();
    tick();
    check("final_drive", obs_vec(), mk(1, 0, 1, 3'd7));
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check("final_stop_nodone", obs_vec(), mk(0, 0, 0, 3'd7));
    tick();
    check("final_stop_after", obs_vec(), mk(0, 0, 0, 3'd7));

    // Maximum dwell gives 256 enabled cycles.
    do_start(8'h04, 8'hFF, 1'b1);
    en_cnt = 0;
    done_cnt = 0;
    bad_sel = 0;
    k = 0;
    while (busy_o && k < 600) begin
      if (g1_en_o) en_cnt++;
      if (g1_en_o && chan_o != 3'd2) bad_sel++;
      if (done_o) done_cnt++;
      tick();
      k++;
    end
    check("maxdwell_timeout", {31'd0, busy_o}, 32'd0);
    check("maxdwell_en_cycles", en_cnt, 32'd256);
    check("maxdwell_sel_stable", bad_sel, 32'd0);
    check("maxdwell_done_early", done_cnt, 32'd0);
    check("maxdwell_done_edge", obs_vec(), mk(0, 1, 0, 3'd2));

    // Asynchronous reset mid-DRIVE.
    tick();
    do_start(8'hFF, 8'd10, 1'b0);
    for (int t = 0; t < 4; t++) tick();
    check("arst_pre", obs_vec(), mk(1, 0, 1, 3'd0));
    mask_i = 8'h10;
    #2 rst_n_i = 1'b0;
    #1;
    check("arst_immediate", obs_vec(), mk(0, 0, 0, 3'd0));
    check("arst_state", {30'd0, state_o}, 32'd0);
    tick();
    check("arst_held", obs_vec(), mk(0, 0, 0, 3'd0));
    rst_n_i = 1'b1;
    tick();
    check("arst_release", obs_vec(), mk(0, 0, 0, 3'd0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_seq_3to8.md
# scan_seq_3to8

Registered scan sequencer that sits directly upstream of the team's 3-to-8 active-low decoder and drives its select and enable pins. It steps through the eight decoder outputs in ascending order, skipping masked channels, holding each one active for a programmable dwell with a blanking gap between channels. Its uses are LED-digit multiplexing and keypad row strobing. Both single-shot and continuous scanning are supported.

## Interface
Parameters:
- DWELL_W, default 8: width of the dwell counter and of dwell_i.
- BLANK_CYCLES, default 2: number of cycles the enables are deasserted before each channel is driven. Legal range is 1 or more; 0 is illegal.

Ports:
- clk_i, input, 1: single clock, rising edge.
- rst_n_i, input, 1: reset, asynchronous, active-low.
- start_i, input, 1: starts a scan when sampled high in IDLE.
- stop_i, input, 1: aborts the scan; has priority over start_i.
- oneshot_i, input, 1: 1 = one pass then stop; 0 = continuous.
- mask_i, input, 8: bit n = 1 means channel n is included in the scan.
- dwell_i, input, DWELL_W: active time per channel, in cycles, is dwell_i + 1.
- busy_o, output, 1: high in any state other than IDLE.
- done_o, output, 1: one-cycle pulse when a single-shot pass completes.
- chan_o, output, 3: current channel number.
- select_a_o, output, 1: decoder select LSB (chan_o[0]).
- select_b_o, output, 1: decoder select (chan_o[1]).
- select_c_o, output, 1: decoder select MSB (chan_o[2]).
- g1_en_o, output, 1: active-high decoder enable.
- g2a_en_n_o, output, 1: active-low decoder enable.
- g2b_en_n_o, output, 1: active-low decoder enable; always equal to g2a_en_n_o.

## Operation
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: busy_o=0, done_o=0, chan_o=0, selects=000, g1_en_o=0, g2a_en_n_o=1, g2b_en_n_o=1. The state is IDLE.
- State IDLE:
  - Enables are deasserted and the selects hold their last value.
  - If start_i=1, stop_i=0 and mask_i≠0: latch mask_i, dwell_i and oneshot_i; load chan with the lowest set mask bit; go to BLANK.
  - If start_i=1 with mask_i=0: ignored. Stay in IDLE, no done_o pulse.
- State BLANK:
  - Enables are deasserted and the selects drive chan, giving address setup before enable.
  - After BLANK_CYCLES cycles, go to DRIVE.
- State DRIVE:
  - g1_en_o=1, g2a_en_n_o=0 and g2b_en_n_o=0.
  - After dwell+1 cycles, search for the next set latched-mask bit above chan.
  - If one is found: load chan with it and go to BLANK.
  - If none is found and oneshot=1: go to IDLE and assert done_o for 1 cycle.
  - If none is found and oneshot=0: wrap chan to the lowest set bit and go to BLANK.
- Latched mask, dwell and oneshot are frozen for the whole scan. Input changes while busy have no effect until the next start.
- start_i while busy is ignored.
- stop_i=1 in BLANK or DRIVE: the next state is IDLE and the enables deassert at the next edge. No done_o pulse; chan holds its value.
- If stop_i and pass-end coincide on the same edge, stop wins and no done_o is issued.
- A single enabled channel in continuous mode repeats BLANK→DRIVE on that same channel indefinitely.
- Dwell counter is DWELL_W bits. dwell_i = 2^DWELL_W−1 gives 2^DWELL_W active cycles with no overflow.

## Timing
- The edge that samples start_i puts busy_o=1 and the first channel on the selects, in BLANK. This is 1-cycle latency from start.
- The enables assert BLANK_CYCLES edges later and stay asserted for dwell+1 cycles.
- Per channel period is BLANK_CYCLES + dwell + 1 cycles.
- The selects change only on a DRIVE→BLANK edge (or IDLE→BLANK). They never change while the enables are asserted.
- done_o and busy_o=0 appear on the same edge that deasserts the enables after the final DRIVE cycle.
- Asynchronous reset mid-scan forces the reset values immediately, independent of the clock.

## Test plan
- Reset: hold rst_n_i=0 mid-DRIVE → all outputs go to their reset values without a clock edge.
- Full one-shot pass: mask=FF, dwell=0, BLANK_CYCLES=2, oneshot=1.
  - Required: channels 0..7 each show 2 blank + 1 enabled cycles.
  - done_o pulses exactly 24 cycles after the start edge; busy_o falls on that same edge.
- Sparse mask, continuous: mask=0x81, dwell=3, oneshot=0.
  - Required: sequence 0,7,0,7… with 4 enabled cycles each; done_o never asserts.
- Zero mask: start with mask=0 → busy_o stays 0 and done_o stays 0.
- Stop during DRIVE of channel 3: enables deassert on the next edge, busy_o=0, no done_o pulse, chan_o=3. A following start_i restarts from the lowest channel.
- Edge cases:
  - stop_i asserted on the final DRIVE cycle of a one-shot pass → no done_o.
  - start_i and mask changes while busy → no effect.
  - dwell=FF with DWELL_W=8 → 256 enabled cycles.
